serial_adder_arbiter: RTL and testbench

Bit-serial adder controller that shares one 1-bit full-adder cell between two requesters. It arbitrates round-robin between the requesters and captures the granted operands. It then sequences the operation LSB-first over WIDTH clock cycles, keeping the carry in a flip-flop, and returns a WIDTH-bit sum plus carry-out with a one-cycle done pulse. The block is the sequencing layer above the combinational full-adder cell (sum = a^b^c, carry = ab + c(a^b)).

---
 rtl/serial_adder_arbiter.sv | 119 +++++++++++
 tb/tb_serial_adder_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_arbiter.sv
// Bit-serial adder controller: round-robin arbitration between two requesters
// over one shared full-adder cell, LSB-first over WIDTH cycles with a carry FF.
module serial_adder_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic             carry_q;
    logic             owner_q;
    logic             last_id_q;
    logic [CW-1:0]    bit_cnt_q;

    logic             s_d;
    logic             c_d;
    logic             pick1_d;
    logic [WIDTH-1:0] res_sr_d;

    always_comb begin
        s_d     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        c_d     = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
        // On a tie, the requester that did not win last time is served.
        pick1_d = req1 & (~req0 | ~last_id_q);
        // Shift-then-overwrite form stays legal when WIDTH is 1.
        res_sr_d            = res_sr_q >> 1;
        res_sr_d[WIDTH-1]   = s_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            res_sr_q  <= '0;
            carry_q   <= 1'b0;
            owner_q   <= 1'b0;
            last_id_q <= 1'b1;
            bit_cnt_q <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        a_sr_q    <= pick1_d ? a1 : a0;
                        b_sr_q    <= pick1_d ? b1 : b0;
                        carry_q   <= pick1_d ? cin1 : cin0;
                        res_sr_q  <= '0;
                        owner_q   <= pick1_d;
                        last_id_q <= pick1_d;
                        bit_cnt_q <= '0;
                        gnt0      <= ~pick1_d;
                        gnt1      <= pick1_d;
                        busy      <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr_q    <= a_sr_q >> 1;
                    b_sr_q    <= b_sr_q >> 1;
                    res_sr_q  <= res_sr_d;
                    carry_q   <= c_d;
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        sum     <= res_sr_d;
                        cout    <= c_d;
                        done_id <= owner_q;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Self-checking bench for serial_adder_arbiter at WIDTH=8 and WIDTH=1.
module tb_serial_adder_arbiter;

    localparam int unsigned NOPS = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       d_req0 = 1'b0, d_req1 = 1'b0, d_cin0 = 1'b0, d_cin1 = 1'b0;
    logic [7:0] d_a0 = '0, d_b0 = '0, d_a1 = '0, d_b1 = '0;
    logic [1:0] rand_mode = '0;

    logic       g0_gnt0, g0_gnt1, g0_busy, g0_done, g0_done_id, g0_cout;
    logic [7:0] g0_sum;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, want);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_w
        localparam int unsigned W = (gi == 0) ? 8 : 1;

        logic         req0, req1, cin0, cin1;
        logic [W-1:0] a0, b0, a1, b1;
        logic         gnt0, gnt1, busy, done, done_id, cout;
        logic [W-1:0] sum;

        logic         rreq0 = 1'b0, rreq1 = 1'b0, rcin0 = 1'b0, rcin1 = 1'b0;
        logic [W-1:0] ra0 = '0, rb0 = '0, ra1 = '0, rb1 = '0;
        int unsigned  issued = 0, cnt_g = 0, cnt_d = 0;
        logic         fin = 1'b0;

        assign req0 = rand_mode[gi] ? rreq0 : d_req0;
        assign req1 = rand_mode[gi] ? rreq1 : d_req1;
        assign cin0 = rand_mode[gi] ? rcin0 : d_cin0;
        assign cin1 = rand_mode[gi] ? rcin1 : d_cin1;
        assign a0   = rand_mode[gi] ? ra0 : d_a0[W-1:0];
        assign b0   = rand_mode[gi] ? rb0 : d_b0[W-1:0];
        assign a1   = rand_mode[gi] ? ra1 : d_a1[W-1:0];
        assign b1   = rand_mode[gi] ? rb1 : d_b1[W-1:0];

        serial_adder_arbiter #(.WIDTH(W)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
            .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
            .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
            .done_id(done_id), .sum(sum), .cout(cout)
        );

        if (gi == 0) begin : g_exp
            assign g0_gnt0    = gnt0;
            assign g0_gnt1    = gnt1;
            assign g0_busy    = busy;
            assign g0_done    = done;
            assign g0_done_id = done_id;
            assign g0_cout    = cout;
            assign g0_sum     = sum;
        end

        // Reference: an operation occupies the adder for W+2 cycles from its grant;
        // result is plain a+b+cin of the winner.
        logic         e_gnt0 = 1'b0, e_gnt1 = 1'b0, e_busy = 1'b0, e_done = 1'b0;
        logic         e_id = 1'b0, e_cout = 1'b0;
        logic [W-1:0] e_sum = '0;
        logic         m_act = 1'b0, m_last = 1'b1, m_own = 1'b0;
        int unsigned  m_age = 0;
        logic [W:0]   m_res = '0;

        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                {e_gnt0, e_gnt1, e_busy, e_done, e_id, e_cout} = '0;
                e_sum  = '0;
                m_act  = 1'b0;
                m_last = 1'b1;
            end else begin
                e_gnt0 = 1'b0;
                e_gnt1 = 1'b0;
                e_done = 1'b0;
                if (m_act) begin
                    m_age++;
                    if (m_age == W) begin
                        e_done          = 1'b1;
                        {e_cout, e_sum} = m_res;
                        e_id            = m_own;
                    end else if (m_age == W + 1) begin
                        m_act  = 1'b0;
                        e_busy = 1'b0;
                    end
                end else if (req0 || req1) begin
                    m_own  = (req0 && req1) ? !m_last : req1;
                    m_last = m_own;
                    m_res  = m_own ? (W+1)'(a1) + (W+1)'(b1) + (W+1)'(cin1)
                                   : (W+1)'(a0) + (W+1)'(b0) + (W+1)'(cin0);
                    m_act  = 1'b1;
                    m_age  = 0;
                    e_busy = 1'b1;
                    e_gnt0 = !m_own;
                    e_gnt1 = m_own;
                end
            end
        end

        initial forever begin
            @(negedge clk);
            chk($sformatf("w%0d_ctrl", W), 64'({gnt0, gnt1, busy, done, done_id, cout}),
                64'({e_gnt0, e_gnt1, e_busy, e_done, e_id, e_cout}));
            chk($sformatf("w%0d_sum", W), 64'(sum), 64'(e_sum));
            if (rand_mode[gi]) begin
                if (gnt0 || gnt1) cnt_g++;
                if (done) cnt_d++;
            end
        end

        initial forever begin
            @(negedge clk);
            if (rand_mode[gi]) begin
                if (rreq0) begin
                    if (gnt0) rreq0 = 1'b0;
                end else if (issued < NOPS && $urandom_range(0, 3) != 0) begin
                    rreq0 = 1'b1;
                    ra0   = W'($urandom);
                    rb0   = W'($urandom);
                    rcin0 = 1'($urandom);
                    issued++;
                end
                if (rreq1) begin
                    if (gnt1) rreq1 = 1'b0;
                end else if (issued < NOPS && $urandom_range(0, 3) != 0) begin
                    rreq1 = 1'b1;
                    ra1   = W'($urandom);
                    rb1   = W'($urandom);
                    rcin1 = 1'($urandom);
                    issued++;
                end
                fin = (issued >= NOPS) && !rreq0 && !rreq1;
            end
        end
    end

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] esum;
        logic       ecout;
    } vec_t;

    task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b, input logic cin);
        if (id) begin
            d_req1 = 1'b1; d_a1 = a; d_b1 = b; d_cin1 = cin;
        end else begin
            d_req0 = 1'b1; d_a0 = a; d_b0 = b; d_cin0 = cin;
        end
    endtask

    task automatic wait_gnt(input string nm);
        int unsigned cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(g0_gnt0 || g0_gnt1) && cyc < 40);
        chk({nm, "_gnt_seen"}, 64'(g0_gnt0 | g0_gnt1), 64'(1));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[6];
        int unsigned lat, span, seen, ng, nd;

        vt[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vt[1] = '{1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vt[2] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vt[4] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vt[5] = '{1'b0, 8'h01, 8'h02, 1'b1, 8'h04, 1'b0};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 64'({g0_gnt0, g0_gnt1, g0_busy, g0_done, g0_done_id, g0_cout, g0_sum}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", 64'({g0_gnt0, g0_gnt1, g0_busy, g0_done, g0_done_id, g0_cout, g0_sum}), 64'(0));

        for (int k = 0; k < 6; k++) begin
            set_req(vt[k].id, vt[k].a, vt[k].b, vt[k].cin);
            wait_gnt("vec");
            chk("vec_gnt1", 64'(g0_gnt1), 64'(vt[k].id));
            chk("vec_gnt0", 64'(g0_gnt0), 64'(!vt[k].id));
            chk("vec_busy_at_gnt", 64'(g0_busy), 64'(1));
            d_req0 = 1'b0;
            d_req1 = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (lat == 1) chk("vec_gnt_pulse", 64'(g0_gnt0 | g0_gnt1), 64'(0));
            end while (!g0_done && lat < 20);
            chk("vec_latency", 64'(lat), 64'(8));
            chk("vec_sum", 64'(g0_sum), 64'(vt[k].esum));
            chk("vec_cout", 64'(g0_cout), 64'(vt[k].ecout));
            chk("vec_done_id", 64'(g0_done_id), 64'(vt[k].id));
            chk("vec_busy_at_done", 64'(g0_busy), 64'(1));
            @(negedge clk);
            chk("vec_done_pulse", 64'(g0_done), 64'(0));
            chk("vec_busy_idle", 64'(g0_busy), 64'(0));
        end

        // Fresh reset, then both requesters held: grants must alternate 0,1,0,1.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d_a0 = 8'h11; d_b0 = 8'h22; d_cin0 = 1'b0;
        d_a1 = 8'h33; d_b1 = 8'h44; d_cin1 = 1'b1;
        d_req0 = 1'b1;
        d_req1 = 1'b1;
        ng = 0;
        nd = 0;
        for (int c = 0; c < 80 && nd < 4; c++) begin
            @(negedge clk);
            if (g0_gnt0 || g0_gnt1) begin
                chk($sformatf("alt_gnt%0d", ng), 64'(g0_gnt1), 64'(ng % 2));
                ng++;
            end
            if (g0_done) begin
                chk($sformatf("alt_done_id%0d", nd), 64'(g0_done_id), 64'(nd % 2));
                chk($sformatf("alt_sum%0d", nd), 64'(g0_sum), (nd % 2 == 0) ? 64'h33 : 64'h78);
                nd++;
            end
        end
        chk("alt_dones", 64'(nd), 64'(4));
        d_req0 = 1'b0;
        d_req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the 4th SHIFT cycle aborts the operation.
        set_req(1'b0, 8'hC3, 8'h1E, 1'b1);
        wait_gnt("rst");
        d_req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_sum", 64'(g0_sum), 64'h78);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", 64'({g0_gnt0, g0_gnt1, g0_busy, g0_done, g0_done_id, g0_cout, g0_sum}), 64'(0));
        repeat (2) @(negedge clk);
        chk("rst_no_done", 64'(g0_done), 64'(0));
        rst_n = 1'b1;
        set_req(1'b0, 8'h0F, 8'h01, 1'b0);
        set_req(1'b1, 8'hF0, 8'h02, 1'b0);
        wait_gnt("rst_tie");
        chk("rst_tie_gnt0", 64'(g0_gnt0), 64'(1));
        chk("rst_tie_gnt1", 64'(g0_gnt1), 64'(0));
        d_req0 = 1'b0;
        d_req1 = 1'b0;
        repeat (12) @(negedge clk);

        // Requester 1 arrives mid-operation: served only once the adder is idle.
        set_req(1'b0, 8'hA5, 8'h5A, 1'b0);
        wait_gnt("late");
        chk("late_first_gnt0", 64'(g0_gnt0), 64'(1));
        d_req0 = 1'b0;
        repeat (2) @(negedge clk);
        set_req(1'b1, 8'h10, 8'h20, 1'b0);
        span = 2;
        seen = 0;
        while (span < 30 && !g0_gnt1) begin
            @(negedge clk);
            span++;
            if (g0_done) begin
                seen++;
                chk("late_r0_sum", 64'(g0_sum), 64'hFF);
                chk("late_r0_cout", 64'(g0_cout), 64'(0));
                chk("late_r0_id", 64'(g0_done_id), 64'(0));
            end
        end
        chk("late_gnt_span", 64'(span), 64'(10));
        chk("late_r0_done_seen", 64'(seen), 64'(1));
        chk("late_gnt1", 64'(g0_gnt1), 64'(1));
        d_req1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!g0_done && lat < 20);
        chk("late_r1_latency", 64'(lat), 64'(8));
        chk("late_r1_sum", 64'(g0_sum), 64'h30);
        chk("late_r1_id", 64'(g0_done_id), 64'(1));
        repeat (14) @(negedge clk);

        rand_mode = 2'b11;
        for (int c = 0; c < 40000 && !(g_w[0].fin && g_w[1].fin); c++) @(negedge clk);
        chk("rand_complete", 64'({g_w[0].fin, g_w[1].fin}), 64'(3));
        repeat (12) @(negedge clk);
        rand_mode = 2'b00;
        chk("rand_w8_grants", 64'(g_w[0].cnt_g), 64'(NOPS));
        chk("rand_w8_dones", 64'(g_w[0].cnt_d), 64'(NOPS));
        chk("rand_w1_grants", 64'(g_w[1].cnt_g), 64'(NOPS));
        chk("rand_w1_dones", 64'(g_w[1].cnt_d), 64'(NOPS));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
